// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 serial transmitter (LSB first) fed by a small write FIFO.
// Bytes pushed with wr_en are queued and sent back-to-back on tx at a fixed
// bit period of CLKS_PER_BIT clock cycles.

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int AW           = $clog2(FIFO_DEPTH)
) (
  input  logic        fpga_clk,
  input  logic        fpga_rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic [AW:0] fifo_count,
  output logic        overflow,
  output logic        busy,
  output logic        tx
);

  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   BAUD_ONE  = BW'(1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]     CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ZERO  = {(AW+1){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic [7:0]      head_s;

  // Occupancy flags are decoded from the registered count, so wr_en never reaches them combinationally.
  always_comb begin
    full_s  = (count_q == CNT_FULL);
    empty_s = (count_q == CNT_ZERO);
    push_s  = wr_en & ~full_s;
    head_s  = mem_q[rd_ptr_q];
  end

  // FIFO bookkeeping: pointers, occupancy and the sticky drop flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // A write seen while full is lost even if the FSM pops on the same edge.
    if (wr_en && full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM: frame sequencing, baud timing and the next tx level.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty_s) begin
          pop_s      = 1'b1;
          shreg_d    = head_s;
          tx_d       = 1'b0;
          baud_cnt_d = {BW{1'b0}};
          state_d    = ST_START;
        end else begin
          baud_cnt_d = {BW{1'b0}};
        end
      end
      ST_START: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = {BW{1'b0}};
          tx_d       = shreg_q[0];
          bit_idx_d  = 3'd0;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = {BW{1'b0}};
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = {BW{1'b0}};
          // Chain straight into the next start bit when more data is queued.
          if (!empty_s) begin
            pop_s   = 1'b1;
            shreg_d = head_s;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      default: begin
        tx_d       = 1'b1;
        baud_cnt_d = {BW{1'b0}};
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State, FIFO control and serial output registers; reset aborts any frame.
  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= {BW{1'b0}};
      bit_idx_q  <= 3'd0;
      shreg_q    <= 8'd0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= CNT_ZERO;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge fpga_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full       = full_s;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != ST_IDLE) | (count_q != CNT_ZERO);
  assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a queue-based
// reference model, a per-cycle output comparison and a serial decoder.

module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       busy;
  logic       tx;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: queued bytes, current frame byte and position in it.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_cur;
  int         m_pos;
  bit         m_active;
  bit         m_ovf;
  bit         m_was_full;

  // Serial decoder state.
  bit         rx_active;
  int         rx_cnt;
  logic [7:0] rx_byte;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .fpga_clk   (clk),
    .fpga_rst_n (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy),
    .tx         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Level of the serial line at cycle pos of a frame carrying byte b.
  function automatic logic frame_bit(input int pos, input logic [7:0] b);
    int k;
    k = pos / CPB;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_ovf    = 1'b0;
    m_cur    = 8'h00;
  endtask

  task automatic model_step();
    m_was_full = (mq.size() == DEPTH);
    if (m_active) begin
      m_pos++;
      if (m_pos == FRAME) begin
        if (mq.size() > 0) begin
          m_cur = mq.pop_front();
          m_pos = 0;
        end else begin
          m_active = 1'b0;
        end
      end
    end else if (mq.size() > 0) begin
      m_cur    = mq.pop_front();
      m_pos    = 0;
      m_active = 1'b1;
    end
    if (wr_en) begin
      if (m_was_full) m_ovf = 1'b1;
      else begin
        mq.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
    end
  endtask

  task automatic compare_step();
    logic exp_tx;
    exp_tx = m_active ? frame_bit(m_pos, m_cur) : 1'b1;
    chk("cyc_tx", {31'd0, tx}, {31'd0, exp_tx});
    chk("cyc_count", {27'd0, fifo_count}, mq.size());
    chk("cyc_full", {31'd0, full}, (mq.size() == DEPTH) ? 32'd1 : 32'd0);
    chk("cyc_busy", {31'd0, busy}, (m_active || mq.size() > 0) ? 32'd1 : 32'd0);
    chk("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  task automatic rx_reset();
    rx_active = 1'b0;
    rx_cnt    = 0;
    rx_byte   = 8'h00;
  endtask

  // Samples each bit in its middle; compares completed bytes against accepted writes.
  task automatic rx_step();
    int j;
    if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % CPB) == (CPB / 2)) begin
        j = rx_cnt / CPB;
        if (j >= 1 && j <= 8) rx_byte[j-1] = tx;
        else if (j == 9) begin
          chk("rx_stop_bit", {31'd0, tx}, 32'd1);
          if (exp_q.size() == 0) chk("rx_unexpected_byte", {24'd0, rx_byte}, 32'hFFFF_FFFF);
          else chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
          rx_active = 1'b0;
        end
      end
    end
  endtask

  // Reference model advances on every rising edge using the driven inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) compare_step();
  end

  // Serial decoder on the tx line.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) rx_reset();
    else rx_step();
  end

  task automatic drive(input logic en, input logic [7:0] d);
    wr_en   = en;
    wr_data = d;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy !== 1'b0 || rx_active) && n < bound) begin
      drive(1'b0, 8'h00);
      n++;
    end
    chk("idle_timeout", (n < bound) ? 32'd1 : 32'd0, 32'd1);
    chk("rx_all_received", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_count", {27'd0, fifo_count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0x5A: start, d0..d7, stop, each CPB cycles.
    pat = 10'b1010110100;
    drive(1'b1, 8'h5A);
    chk("t1_count_after_write", {27'd0, fifo_count}, 32'd1);
    chk("t1_tx_still_idle", {31'd0, tx}, 32'd1);
    for (int k = 0; k < FRAME; k++) begin
      drive(1'b0, 8'h00);
      chk("t1_tx_pattern", {31'd0, tx}, {31'd0, pat[k / CPB]});
      if (k == 0) chk("t1_count_after_pop", {27'd0, fifo_count}, 32'd0);
    end
    chk("t1_busy_in_stop", {31'd0, busy}, 32'd1);
    drive(1'b0, 8'h00);
    chk("t1_busy_done", {31'd0, busy}, 32'd0);
    chk("t1_tx_idle", {31'd0, tx}, 32'd1);
    wait_idle(100);

    // Three bytes back-to-back: start bits exactly one frame apart.
    drive(1'b1, 8'h8F);
    drive(1'b1, 8'h07);
    drive(1'b1, 8'h5A);
    idle_cycles(38);
    chk("t2_stop1", {31'd0, tx}, 32'd1);
    idle_cycles(1);
    chk("t2_start2", {31'd0, tx}, 32'd0);
    idle_cycles(39);
    chk("t2_stop2", {31'd0, tx}, 32'd1);
    idle_cycles(1);
    chk("t2_start3", {31'd0, tx}, 32'd0);
    wait_idle(200);

    // Push and pop on the same edge with one entry queued.
    drive(1'b1, 8'hA1);
    drive(1'b1, 8'hB2);
    idle_cycles(39);
    chk("t3_count_before", {27'd0, fifo_count}, 32'd1);
    drive(1'b1, 8'hC3);
    chk("t3_count_same", {27'd0, fifo_count}, 32'd1);
    chk("t3_next_start", {31'd0, tx}, 32'd0);
    wait_idle(300);

    // Fill to full, then one dropped write.
    for (int i = 0; i < 17; i++) drive(1'b1, 8'h10 + 8'(i));
    chk("t4_count_full", {27'd0, fifo_count}, 32'd16);
    chk("t4_full", {31'd0, full}, 32'd1);
    chk("t4_no_overflow", {31'd0, overflow}, 32'd0);
    drive(1'b1, 8'hEE);
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    chk("t4_count_kept", {27'd0, fifo_count}, 32'd16);
    wait_idle(17 * FRAME + 100);
    chk("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Reset during data bit 3 of 0xF7 (bit 3 is 0) with a second byte queued.
    drive(1'b1, 8'hF7);
    drive(1'b1, 8'h33);
    idle_cycles(17);
    chk("t5_tx_d3_low", {31'd0, tx}, 32'd0);
    chk("t5_count_before", {27'd0, fifo_count}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", {31'd0, tx}, 32'd1);
    chk("t5_rst_count", {27'd0, fifo_count}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 8'h07);
    wait_idle(100);

    // Pointer wrap: 40 bytes, a burst of 10 then one per frame.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(i));
      if (i >= 9) idle_cycles(FRAME - 1);
    end
    chk("t6_no_overflow", {31'd0, overflow}, 32'd0);
    wait_idle(20 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
